// File: rtl/adder_acc_pkg.sv
// Shared definitions for the adder/accumulator block: operation encoding
// used by the control path in adder_acc and the datapath in adder_acc_alu.
package adder_acc_pkg;

  typedef enum logic [1:0] {
    MODE_ADD    = 2'd0,
    MODE_SUB    = 2'd1,
    MODE_ACC    = 2'd2,
    MODE_SATADD = 2'd3
  } mode_e;

endpackage : adder_acc_pkg

// File: rtl/adder_acc_alu.sv
// Purely combinational arithmetic for adder_acc: computes the candidate
// result and whether the selected operation overflowed or underflowed.
module adder_acc_alu
  import adder_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  mode_e            mode,
  output logic [WIDTH-1:0] value,
  output logic             ovf_set
);

  // One guard bit on each sum exposes carry-out (or borrow for SUB).
  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;
  logic [WIDTH:0] acc_w;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign acc_w = {1'b0, acc} + {1'b0, a};

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    value   = add_w[WIDTH-1:0];
    ovf_set = add_w[WIDTH];
    case (mode)
      MODE_ADD: begin
        value   = add_w[WIDTH-1:0];
        ovf_set = add_w[WIDTH];
      end
      MODE_SUB: begin
        value   = sub_w[WIDTH-1:0];
        ovf_set = sub_w[WIDTH];
      end
      MODE_ACC: begin
        value   = acc_w[WIDTH-1:0];
        ovf_set = acc_w[WIDTH];
      end
      MODE_SATADD: begin
        value   = add_w[WIDTH] ? {WIDTH{1'b1}} : add_w[WIDTH-1:0];
        ovf_set = add_w[WIDTH];
      end
    endcase
  end

endmodule : adder_acc_alu

// File: rtl/adder_acc.sv
// Adder/accumulator with a one-deep valid/ready output register, a sticky
// overflow flag and a count of accepted operations.
module adder_acc
  import adder_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q,       ovf_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic             accept;
  logic [WIDTH-1:0] alu_value;
  logic             alu_ovf;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  // The output slot is free when empty or being drained this same cycle,
  // which gives full throughput under continuous out_ready.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !clr;

  adder_acc_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a       (a),
    .b       (b),
    .acc     (acc_q),
    .mode    (mode_sel),
    .value   (alu_value),
    .ovf_set (alu_ovf)
  );

  always_comb begin
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;

    if (accept) begin
      result_d    = alu_value;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // clr touches only the bookkeeping state; the output register is left
    // to the handshake so a pending result is not lost.
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (accept) begin
      if (mode_sel == MODE_ACC) acc_d = alu_value;
      if (alu_ovf) ovf_d = 1'b1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign op_count  = cnt_q;

endmodule : adder_acc

// File: doc/adder_acc.md
ADDER_ACC -- requirements
Module: adder_acc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand, result and accumulator width in bits (WIDTH >= 2).
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning width of the accepted-operation counter.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The module SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-006 The module SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-007 The module SHALL have port mode  input  2  operation select: 0 ADD, 1 SUB, 2 ACC, 3 SATADD.
REQ-008 The module SHALL have port in_valid  input  1  a, b and mode are valid this cycle.
REQ-009 The module SHALL have port in_ready  output  1  the module accepts an operation this cycle.
REQ-010 The module SHALL have port clr  input  1  synchronous clear of accumulator, sticky flag and counter.
REQ-011 The module SHALL have port result  output  WIDTH  registered operation result.
REQ-012 The module SHALL have port out_valid  output  1  result holds an unconsumed value.
REQ-013 The module SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-014 The module SHALL have port ovf  output  1  sticky overflow/underflow flag.
REQ-015 The module SHALL have port op_count  output  CNT_W  number of accepted operations since reset/clr.

Function
REQ-016 An operation SHALL be accepted when in_valid and in_ready are both 1 on a rising edge and clr is 0.
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-018 result and out_valid SHALL update exactly one cycle after acceptance (latency 1).
REQ-019 ADD SHALL produce (a+b) mod 2^WIDTH; carry-out SHALL set ovf.
REQ-020 SUB SHALL produce (a-b) mod 2^WIDTH; borrow (a<b) SHALL set ovf.
REQ-021 ACC SHALL set acc <= (acc+a) mod 2^WIDTH and result <= the new acc; carry-out SHALL set ovf; b is ignored.
REQ-022 SATADD SHALL produce min(a+b, 2^WIDTH-1); saturation SHALL set ovf.
REQ-023 Only ACC SHALL modify acc; other modes SHALL leave acc unchanged.
REQ-024 ovf SHALL remain 1 once set until clr or rst.
REQ-025 op_count SHALL increment by 1 per accepted operation and wrap from 2^CNT_W-1 to 0.
REQ-026 When out_valid=1 and out_ready=0, result SHALL hold stable and in_ready SHALL be 0.
REQ-027 When out_valid=1, out_ready=1 and no acceptance, out_valid SHALL clear next cycle.
REQ-028 Acceptance and consumption in the same cycle SHALL load the new result with out_valid staying 1 (full throughput).
REQ-029 clr=1 SHALL zero acc, ovf and op_count next edge, discard any in_valid that cycle, and leave result/out_valid unaffected.

Reset
REQ-030 rst=1 SHALL immediately set acc=0, result=0, out_valid=0, ovf=0, op_count=0, independent of clk.
REQ-031 rst asserted mid-operation SHALL drop any pending result; in_ready SHALL read 1 during and after reset.

Structure
REQ-032 A shared package SHALL hold the mode encoding constants (MODE_ADD, MODE_SUB, MODE_ACC, MODE_SATADD).
REQ-033 Combinational arithmetic SHALL live in one sub-module, adder_acc_alu (inputs a, b, acc, mode; outputs value, ovf_set), with all state in adder_acc.

Verification
REQ-034 WIDTH=8: ADD a=200,b=100 -> result=44, ovf=1, op_count=1, one cycle after acceptance.
REQ-035 WIDTH=8: SATADD a=200,b=100 -> result=255, ovf=1; SATADD a=10,b=20 after clr -> result=30, ovf=0.
REQ-036 WIDTH=8: SUB a=5,b=7 -> result=254, ovf=1; SUB a=7,b=5 -> result=2.
REQ-037 ACC a=100 three times, out_ready=1 -> results 100, 200, 44; ovf set on third; op_count=3.
REQ-038 Backpressure: out_ready=0 with two ADD offers -> first result held, in_ready=0, second accepted only after out_ready=1.
REQ-039 clr with in_valid simultaneously, then rst mid-stream -> op_count=0, op dropped; all outputs 0 asynchronously on rst.
